// File: rtl/vec_dispatch_pkg.sv
// Shared types, opcode/funct constants and helpers for the vector dispatch stage.
// Optional perf counters elsewhere are enabled by VEC_DISPATCH_PERF_EN.
package vec_dispatch_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    MUL_WAIT
  } state_t;

  localparam logic [6:0] OPC_VLOAD  = 7'b0000111;
  localparam logic [6:0] OPC_VSTORE = 7'b0100111;

  localparam logic [2:0] F3_OPIVI = 3'b011;
  localparam logic [2:0] F3_OPMVV = 3'b010;
  localparam logic [2:0] F3_OPMVX = 3'b110;

  localparam logic [8:0] VADC_VV = 9'b000010000;
  localparam logic [8:0] VADC_VX = 9'b100010000;
  localparam logic [8:0] VADC_VI = 9'b011010000;

  localparam logic [5:0] F6_VMULHU  = 6'b100100;
  localparam logic [5:0] F6_VMUL    = 6'b100101;
  localparam logic [5:0] F6_VMULHSU = 6'b100110;
  localparam logic [5:0] F6_VMULH   = 6'b100111;
  localparam logic [5:0] F6_VMADD   = 6'b101001;
  localparam logic [5:0] F6_VMACC   = 6'b101101;

  function automatic logic [63:0] replicate_by_sew(
    input logic [63:0] data,
    input logic [2:0]  sew
  );
    logic [63:0] r;
    r = '0;
    case (sew)
      3'd0:    r = {8{data[7:0]}};
      3'd1:    r = {4{data[15:0]}};
      3'd2:    r = {2{data[31:0]}};
      3'd3:    r = data;
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic logic is_vadc(input logic [8:0] op);
    return op inside {VADC_VV, VADC_VX, VADC_VI};
  endfunction

  function automatic logic is_mul(input logic [8:0] op);
    return (op[8:6] inside {F3_OPMVV, F3_OPMVX}) &&
           (op[5:0] inside {F6_VMULHU, F6_VMUL, F6_VMULHSU,
                            F6_VMULH, F6_VMADD, F6_VMACC});
  endfunction

endpackage

// File: rtl/vec_dispatch_if.sv
// Instruction-in and micro-op-out handshake bundle of the dispatch stage.
// Perf counter wires exist only with VEC_DISPATCH_PERF_EN.
interface vec_dispatch_if #(
  parameter int DATA_FROM_SCALAR = 96,
  parameter int LANES_DATA_WIDTH = 64,
  parameter int MICROOP_BIT      = 9,
  parameter int MAX_LMUL         = 8
);
  localparam int IW = $clog2(MAX_LMUL) + 1;

  logic [DATA_FROM_SCALAR-1:0] instruction_in;
  logic                        valid_instruction;
  logic                        ready_vector;
  logic [2:0]                  sew_in;
  logic [1:0]                  lmul_in;
  logic                        uop_valid;
  logic                        uop_ready;
  logic [MICROOP_BIT-1:0]      uop_alu_op;
  logic [4:0]                  uop_operand_1;
  logic [4:0]                  uop_operand_2;
  logic [4:0]                  uop_destination;
  logic [LANES_DATA_WIDTH-1:0] uop_data_1;
  logic [IW-1:0]               uop_index;
  logic                        uop_last;
  logic                        uop_masked;
  logic                        uop_multiplication_flag;
  logic                        uop_load;
  logic                        uop_store;
  logic                        busy;
`ifdef VEC_DISPATCH_PERF_EN
  logic [31:0]                 perf_uops_issued;
  logic [31:0]                 perf_stall_cycles;
`endif

  modport master (
    output instruction_in, valid_instruction, sew_in, lmul_in, uop_ready,
    input  ready_vector, uop_valid, uop_alu_op, uop_operand_1,
    input  uop_operand_2, uop_destination, uop_data_1, uop_index,
    input  uop_last, uop_masked, uop_multiplication_flag,
    input  uop_load, uop_store, busy
`ifdef VEC_DISPATCH_PERF_EN
    , input perf_uops_issued, perf_stall_cycles
`endif
  );

  modport slave (
    input  instruction_in, valid_instruction, sew_in, lmul_in, uop_ready,
    output ready_vector, uop_valid, uop_alu_op, uop_operand_1,
    output uop_operand_2, uop_destination, uop_data_1, uop_index,
    output uop_last, uop_masked, uop_multiplication_flag,
    output uop_load, uop_store, busy
`ifdef VEC_DISPATCH_PERF_EN
    , output perf_uops_issued, perf_stall_cycles
`endif
  );

endinterface

// File: rtl/vec_dispatch_seq_sequencer.sv
// Group sequencer: FSM, micro-op index and multiply wait counter.
module vec_uop_sequencer
  import vec_dispatch_pkg::*;
#(
  parameter  int MAX_LMUL    = 8,
  parameter  int MUL_LATENCY = 3,
  localparam int KW          = $clog2(MAX_LMUL) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [1:0]    lmul,
  input  logic          mul,
  input  logic          ready,
  output state_t        state,
  output logic [KW-1:0] k,
  output logic          valid,
  output logic          last,
  output logic          done
);
  localparam int LOG_MAX = $clog2(MAX_LMUL);
  localparam int WW      = $clog2(MUL_LATENCY) + 1;
  localparam logic [WW-1:0] WAIT_INIT = WW'(MUL_LATENCY - 1);

  state_t        state_n;
  logic [KW-1:0] k_n;
  logic [KW-1:0] gm1;
  logic [WW-1:0] wcnt;
  logic [WW-1:0] wcnt_n;
  logic [1:0]    glog;
  logic [1:0]    glog_c;

  assign glog_c = (int'(lmul) > LOG_MAX) ? 2'(LOG_MAX) : lmul;
  assign gm1    = KW'((1 << glog) - 1);
  assign last   = (state == ISSUE) && (k == gm1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      k     <= '0;
      wcnt  <= '0;
      glog  <= '0;
    end else begin
      state <= state_n;
      k     <= k_n;
      wcnt  <= wcnt_n;
      if (start) glog <= glog_c;
    end
  end

  always_comb begin
    state_n = state;
    k_n     = k;
    wcnt_n  = wcnt;
    valid   = 1'b0;
    done    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_n = ISSUE;
          k_n     = '0;
        end
      end
      ISSUE: begin
        valid = 1'b1;
        if (ready) begin
          if (k == gm1) begin
            state_n = IDLE;
            done    = 1'b1;
          end else if (mul && (MUL_LATENCY > 1)) begin
            state_n = MUL_WAIT;
            wcnt_n  = WAIT_INIT;
          end else begin
            k_n = k + 1'b1;
          end
        end
      end
      MUL_WAIT: begin
        if (wcnt <= WW'(1)) begin
          state_n = ISSUE;
          k_n     = k + 1'b1;
        end else begin
          wcnt_n = wcnt - 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: rtl/vec_dispatch_seq.sv
// Vector dispatch: latches one instruction and expands it into LMUL micro-ops.
// Define VEC_DISPATCH_PERF_EN for saturating issue/stall counters.
module vec_dispatch_seq
  import vec_dispatch_pkg::*;
#(
  parameter int INSTRUCTION_BITS  = 32,
  parameter int DATA_FROM_SCALAR  = 96,
  parameter int SCALAR_DATA_WIDTH = 32,
  parameter int LANES_DATA_WIDTH  = 64,
  parameter int MICROOP_BIT       = 9,
  parameter int MAX_LMUL          = 8,
  parameter int MUL_LATENCY       = 3
) (
  input logic          clk,
  input logic          rst,
  vec_dispatch_if.slave bus
);
  localparam int KW  = $clog2(MAX_LMUL) + 1;
  localparam int REP = LANES_DATA_WIDTH / 64;

  logic [INSTRUCTION_BITS-1:0]  instr;
  logic [SCALAR_DATA_WIDTH-1:0] op1;
  logic                         unused_op2;
  logic [8:0]                   alu;
  logic [63:0]                  imm64;
  logic [63:0]                  scl64;
  logic [63:0]                  rep64;
  logic                         accept;
  state_t                       state;
  logic [KW-1:0]                k;
  logic                         unused_done;

  logic [4:0]                  vs1_q;
  logic [4:0]                  vs2_q;
  logic [4:0]                  vd_q;
  logic [MICROOP_BIT-1:0]      alu_q;
  logic [LANES_DATA_WIDTH-1:0] data_q;
  logic                        masked_q;
  logic                        mul_q;
  logic                        load_q;
  logic                        store_q;

  assign instr = bus.instruction_in[DATA_FROM_SCALAR-1 -: INSTRUCTION_BITS];
  assign op1   = bus.instruction_in[SCALAR_DATA_WIDTH-1:0];
  assign unused_op2 =
    ^bus.instruction_in[DATA_FROM_SCALAR-INSTRUCTION_BITS-1:SCALAR_DATA_WIDTH];

  assign alu   = {instr[14:12], instr[31:26]};
  assign imm64 = {{59{instr[19]}}, instr[19:15]};
  assign scl64 = 64'($signed(op1));
  // imm vs scalar picks the source; SEW truncation happens in the replicate
  assign rep64 = replicate_by_sew(
    (instr[14:12] == F3_OPIVI) ? imm64 : scl64, bus.sew_in);

  assign accept           = bus.valid_instruction && bus.ready_vector;
  assign bus.ready_vector = (state == IDLE);
  assign bus.busy         = (state != IDLE);

  vec_uop_sequencer #(
    .MAX_LMUL    (MAX_LMUL),
    .MUL_LATENCY (MUL_LATENCY)
  ) u_seq (
    .clk   (clk),
    .rst   (rst),
    .start (accept),
    .lmul  (bus.lmul_in),
    .mul   (mul_q),
    .ready (bus.uop_ready),
    .state (state),
    .k     (k),
    .valid (bus.uop_valid),
    .last  (bus.uop_last),
    .done  (unused_done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vs1_q    <= '0;
      vs2_q    <= '0;
      vd_q     <= '0;
      alu_q    <= '0;
      data_q   <= '0;
      masked_q <= 1'b0;
      mul_q    <= 1'b0;
      load_q   <= 1'b0;
      store_q  <= 1'b0;
    end else if (accept) begin
      vs1_q    <= instr[19:15];
      vs2_q    <= instr[24:20];
      vd_q     <= instr[11:7];
      alu_q    <= MICROOP_BIT'(alu);
      data_q   <= {REP{rep64}};
      masked_q <= !is_vadc(alu) && !instr[25];
      mul_q    <= is_mul(alu);
      load_q   <= (instr[6:0] == OPC_VLOAD);
      store_q  <= (instr[6:0] == OPC_VSTORE);
    end
  end

  assign bus.uop_operand_1           = vs1_q + 5'(k);
  assign bus.uop_operand_2           = vs2_q + 5'(k);
  assign bus.uop_destination         = vd_q + 5'(k);
  assign bus.uop_index               = k;
  assign bus.uop_alu_op              = alu_q;
  assign bus.uop_data_1              = data_q;
  assign bus.uop_masked              = masked_q;
  assign bus.uop_multiplication_flag = mul_q;
  assign bus.uop_load                = load_q;
  assign bus.uop_store               = store_q;

`ifdef VEC_DISPATCH_PERF_EN
  logic [31:0] uops_q;
  logic [31:0] stall_q;
  logic        stall;

  assign stall = (bus.uop_valid && !bus.uop_ready) || (state == MUL_WAIT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      uops_q  <= '0;
      stall_q <= '0;
    end else begin
      if (bus.uop_valid && bus.uop_ready && (uops_q != '1))
        uops_q <= uops_q + 1'b1;
      if (stall && (stall_q != '1))
        stall_q <= stall_q + 1'b1;
    end
  end

  assign bus.perf_uops_issued  = uops_q;
  assign bus.perf_stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_vec_dispatch_seq.sv
// Directed plus randomized bench for vec_dispatch_seq against a group-level model.
module tb_vec_dispatch_seq;
  localparam int MUL_LAT = 3;
  localparam logic [6:0] OPV = 7'b1010111;

  logic clk = 1'b0;
  logic rst;
  int checks = 0;
  int failures = 0;
  logic [63:0] last_data;
  logic last_masked;

  vec_dispatch_if bus ();

  vec_dispatch_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #800000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [5:0] f6, input logic vm,
    input logic [4:0] vs2, input logic [4:0] vs1, input logic [2:0] f3,
    input logic [4:0] vd, input logic [6:0] opc);
    return {f6, vm, vs2, vs1, f3, vd, opc};
  endfunction

  function automatic int gsize(input logic [1:0] lmul);
    int l;
    l = int'(lmul);
    if (l > 3) l = 3;
    return 1 << l;
  endfunction

  function automatic logic [63:0] m_data(input logic [31:0] ins,
    input logic [31:0] op1, input logic [2:0] sew);
    longint v;
    int bits;
    logic [63:0] elem, res;
    if (sew > 3) return 64'd0;
    bits = 8 << sew;
    if (ins[14:12] == 3'b011) v = longint'($signed(ins[19:15]));
    else v = longint'($signed(op1));
    elem = (bits == 64) ? v : (v & ((64'd1 << bits) - 64'd1));
    res = 64'd0;
    for (int i = 0; i < 64 / bits; i++) res = res | (elem << (i * bits));
    return res;
  endfunction

  function automatic logic m_vadc(input logic [31:0] ins);
    logic [8:0] op;
    op = {ins[14:12], ins[31:26]};
    return op == 9'b000010000 || op == 9'b100010000 || op == 9'b011010000;
  endfunction

  function automatic logic m_mul(input logic [31:0] ins);
    int f6;
    f6 = int'(ins[31:26]);
    return (ins[14:12] == 3'b010 || ins[14:12] == 3'b110) &&
           (f6 == 36 || f6 == 37 || f6 == 38 || f6 == 39 ||
            f6 == 41 || f6 == 45);
  endfunction

  task automatic check_uop(input logic [31:0] ins, input logic [31:0] op1,
    input logic [2:0] sew, input int k, input int group);
    check("index", bus.uop_index, k);
    check("last", bus.uop_last, (k == group - 1));
    check("vs1", bus.uop_operand_1, (int'(ins[19:15]) + k) % 32);
    check("vs2", bus.uop_operand_2, (int'(ins[24:20]) + k) % 32);
    check("vd", bus.uop_destination, (int'(ins[11:7]) + k) % 32);
    check("alu_op", bus.uop_alu_op, {ins[14:12], ins[31:26]});
    check("data_1", bus.uop_data_1, m_data(ins, op1, sew));
    check("masked", bus.uop_masked, !m_vadc(ins) && !ins[25]);
    check("mul", bus.uop_multiplication_flag, m_mul(ins));
    check("load", bus.uop_load, ins[6:0] == 7'b0000111);
    check("store", bus.uop_store, ins[6:0] == 7'b0100111);
    last_data = bus.uop_data_1;
    last_masked = bus.uop_masked;
  endtask

  // called at a negedge with the block idle
  task automatic send(input logic [31:0] ins, input logic [31:0] op1,
    input logic [2:0] sew, input logic [1:0] lmul, input bit rnd);
    int group, k, gap, cyc, exp_gap;
    bit pending;
    group = gsize(lmul);
    exp_gap = m_mul(ins) ? MUL_LAT - 1 : 0;
    check("ready_idle", bus.ready_vector, 1'b1);
    bus.instruction_in = {ins, $urandom, op1};
    bus.sew_in = sew;
    bus.lmul_in = lmul;
    bus.valid_instruction = 1'b1;
    bus.uop_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus.valid_instruction = 1'b0;
    bus.instruction_in = {$urandom, $urandom, $urandom};
    bus.sew_in = 3'($urandom);
    bus.lmul_in = 2'($urandom);
    k = 0; gap = 0; cyc = 0; pending = 1'b1;
    while (k < group && cyc < 200) begin
      cyc++;
      bus.uop_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (bus.uop_valid) begin
        if (pending) check("gap", gap, (k == 0) ? 0 : exp_gap);
        pending = 1'b0;
        check_uop(ins, op1, sew, k, group);
        check("busy_issue", bus.busy, 1'b1);
        check("ready_busy", bus.ready_vector, 1'b0);
        if (bus.uop_ready) begin
          k++;
          gap = 0;
          pending = 1'b1;
        end
      end else begin
        gap++;
      end
      @(posedge clk);
      @(negedge clk);
    end
    if (k < group) check("timeout", k, group);
    bus.uop_ready = 1'b0;
    check("ready_after", bus.ready_vector, 1'b1);
    check("valid_after", bus.uop_valid, 1'b0);
    check("busy_after", bus.busy, 1'b0);
  endtask

  initial begin
    logic [31:0] ins;
    logic [5:0] f6s [6];
    logic [2:0] f3s [5];
    logic [6:0] opcs [3];
    rst = 1'b1;
    bus.instruction_in = '0;
    bus.valid_instruction = 1'b0;
    bus.sew_in = 3'd0;
    bus.lmul_in = 2'd0;
    bus.uop_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_valid", bus.uop_valid, 1'b0);
    check("rst_busy", bus.busy, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    check("init_ready", bus.ready_vector, 1'b1);
    check("init_index", bus.uop_index, 0);
    check("init_last", bus.uop_last, 1'b0);
    check("init_data", bus.uop_data_1, 64'd0);
    check("init_alu", bus.uop_alu_op, 9'd0);
    check("init_masked", bus.uop_masked, 1'b0);

    send(mk(6'b000000, 1'b1, 5'd8, 5'd12, 3'b000, 5'd4, OPV), 32'h0, 3'd2, 2'd0, 0);
    send(mk(6'b000000, 1'b1, 5'd8, 5'd16, 3'b000, 5'd30, OPV), 32'h0, 3'd2, 2'd2, 0);
    send(mk(6'b100101, 1'b1, 5'd2, 5'd5, 3'b110, 5'd10, OPV), 32'h1234_5678,
         3'd2, 2'd1, 0);

    ins = mk(6'b000000, 1'b1, 5'd3, 5'b10110, 3'b011, 5'd7, OPV);
    send(ins, 32'h0, 3'd0, 2'd0, 0);
    check("vi_sew0", last_data, 64'hF6F6F6F6F6F6F6F6);
    send(ins, 32'h0, 3'd3, 2'd0, 0);
    check("vi_sew3", last_data, 64'hFFFFFFFFFFFFFFF6);

    send(mk(6'b010000, 1'b0, 5'd4, 5'd5, 3'b000, 5'd6, OPV), 32'h0, 3'd0, 2'd0, 0);
    check("vadc_unmasked", last_masked, 1'b0);
    send(mk(6'b000000, 1'b0, 5'd4, 5'd5, 3'b000, 5'd6, OPV), 32'h0, 3'd0, 2'd0, 0);
    check("vadd_masked", last_masked, 1'b1);

    // stall mid-group, then reset abandons the group
    ins = mk(6'b000000, 1'b1, 5'd8, 5'd16, 3'b000, 5'd30, OPV);
    bus.instruction_in = {ins, 32'h0, 32'h0};
    bus.sew_in = 3'd1;
    bus.lmul_in = 2'd2;
    bus.valid_instruction = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.valid_instruction = 1'b0;
    bus.uop_ready = 1'b1;
    check_uop(ins, 32'h0, 3'd1, 0, 4);
    @(posedge clk);
    @(negedge clk);
    bus.uop_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("stall_valid", bus.uop_valid, 1'b1);
      check("stall_ready_vector", bus.ready_vector, 1'b0);
      check_uop(ins, 32'h0, 3'd1, 1, 4);
      @(posedge clk);
      @(negedge clk);
    end
    rst = 1'b1;
    #1;
    check("midrst_valid", bus.uop_valid, 1'b0);
    check("midrst_busy", bus.busy, 1'b0);
    check("midrst_ready", bus.ready_vector, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    bus.uop_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("post_rst_valid", bus.uop_valid, 1'b0);
    end
    bus.uop_ready = 1'b0;

    f6s[0] = 6'b000000; f6s[1] = 6'b100101; f6s[2] = 6'b100100;
    f6s[3] = 6'b101101; f6s[4] = 6'b010000; f6s[5] = 6'b000000;
    f3s[0] = 3'b000; f3s[1] = 3'b010; f3s[2] = 3'b011;
    f3s[3] = 3'b100; f3s[4] = 3'b110;
    opcs[0] = OPV; opcs[1] = 7'b0000111; opcs[2] = 7'b0100111;
    for (int n = 0; n < 40; n++) begin
      logic [5:0] f6;
      f6 = (n % 5 == 4) ? 6'($urandom) : f6s[$urandom_range(0, 5)];
      ins = mk(f6, 1'($urandom), 5'($urandom), 5'($urandom),
               f3s[$urandom_range(0, 4)], 5'($urandom),
               opcs[$urandom_range(0, 2)]);
      send(ins, $urandom, 3'($urandom), 2'($urandom), 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
